seq_div_ctrl: RTL

Sequential controller for the 16/8 unsigned divider: accepts a dividend/divisor pair over a valid/ready handshake and runs a restoring division, one quotient bit per cycle, through a single shared 9-bit borrow-chain subtractor row instead of a full 8-row array. It screens for divide-by-zero and quotient overflow before iterating, then returns the quotient and remainder over a second valid/ready handshake. It sits between the operand source and the result consumer.

---
 rtl/div_pkg.sv | 20 ++
 rtl/div_sub_row.sv | 46 ++++
 rtl/seq_div_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared types and widths for the sequential 16/8 unsigned divider.
package div_pkg;

    localparam int DVS_W = 8;
    localparam int DVD_W = 2 * DVS_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ITER  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        ERR_OK   = 2'b00,
        ERR_DIV0 = 2'b01,
        ERR_OVF  = 2'b10
    } err_t;

endpackage

// File: rtl/div_sub_row.sv
// One borrow-chain subtractor row (d = a - b) built from exdcr cells.
// Each cell may be swapped for an approximate variant via APPROX_MASK.

// Single full-subtractor cell; APPROX drops the borrow-in from the
// borrow-out term (sum bit stays exact).
module exdcr #(
    parameter bit APPROX = 1'b0
) (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d = a ^ b ^ bin;
    if (APPROX) begin : g_apx
        assign bout = ~a & b;
    end else begin : g_exact
        assign bout = (~a & b) | (~(a ^ b) & bin);
    end
endmodule

module div_sub_row #(
    parameter int             W           = 9,
    parameter logic [W-1:0]   APPROX_MASK = '0
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] d,
    output logic         bout
);
    logic [W:0] bc;

    assign bc[0] = 1'b0;
    assign bout  = bc[W];

    for (genvar i = 0; i < W; i++) begin : g_cell
        exdcr #(.APPROX(APPROX_MASK[i])) u_cell (
            .a    (a[i]),
            .b    (b[i]),
            .bin  (bc[i]),
            .d    (d[i]),
            .bout (bc[i+1])
        );
    end
endmodule

// File: rtl/seq_div_ctrl.sv
// Sequential restoring divider controller: screens for divide-by-zero and
// quotient overflow, then iterates one quotient bit per cycle through a
// single shared subtractor row.
module seq_div_ctrl
    import div_pkg::*;
#(
    parameter int DVS_W = div_pkg::DVS_W,
    parameter int DVD_W = 2 * DVS_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DVD_W-1:0] x,
    input  logic [DVS_W-1:0] y,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DVS_W-1:0] q,
    output logic [DVS_W-1:0] r,
    output logic [1:0]       err,
    output logic             busy
);
    localparam int CW = $clog2(DVS_W);

    state_t           state, state_nx;
    logic [DVD_W-1:0] xr;
    logic [DVS_W-1:0] yr;
    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] quo;
    logic [CW-1:0]    cnt;

    logic [DVS_W-1:0] xhi, xlo;
    logic [DVS_W:0]   t, d;
    logic             bout, qbit, sub_unused;
    logic [DVS_W-1:0] rem_nx;
    logic             div0, ovf, last;

    assign xhi = xr[DVD_W-1:DVS_W];
    assign xlo = xr[DVS_W-1:0];

    // T = {R, next dividend bit}; the row computes T - {0, y}
    assign t = {rem, xlo[cnt]};

    div_sub_row #(.W(DVS_W + 1)) u_row (
        .a    (t),
        .b    ({1'b0, yr}),
        .d    (d),
        .bout (bout)
    );

    // With R < y held as an invariant, a non-borrowing result always fits
    // in DVS_W bits, so the row's top difference bit is never needed.
    assign sub_unused = d[DVS_W];
    assign qbit       = ~bout;
    assign rem_nx     = bout ? t[DVS_W-1:0] : d[DVS_W-1:0];

    assign div0 = (yr == '0);
    assign ovf  = (xhi >= yr);
    assign last = (cnt == '0);

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; abort only cancels work that has not yet produced a result
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (in_valid) state_nx = CHECK;
            CHECK: begin
                if (abort)            state_nx = IDLE;
                else if (div0 || ovf) state_nx = DONE;
                else                  state_nx = ITER;
            end
            ITER: begin
                if (abort)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE:  if (out_valid && out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand latch, iteration registers and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xr  <= '0;
            yr  <= '0;
            rem <= '0;
            quo <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            err <= ERR_OK;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xr <= x;
                    yr <= y;
                end
                CHECK: if (!abort) begin
                    if (div0) begin
                        q   <= '1;
                        r   <= '1;
                        err <= ERR_DIV0;
                    end else if (ovf) begin
                        q   <= '1;
                        r   <= '1;
                        err <= ERR_OVF;
                    end else begin
                        rem <= xhi;
                        quo <= '0;
                        cnt <= CW'(DVS_W - 1);
                    end
                end
                ITER: if (!abort) begin
                    rem <= rem_nx;
                    quo <= {quo[DVS_W-2:0], qbit};
                    cnt <= cnt - 1'b1;
                    if (last) begin
                        q   <= {quo[DVS_W-2:0], qbit};
                        r   <= rem_nx;
                        err <= ERR_OK;
                    end
                end
                default: ;
            endcase
        end
    end

    // out_valid is registered one cycle behind DONE entry and drops on the
    // handshake edge, together with the return to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_valid <= 1'b0;
        else        out_valid <= (state == DONE) && !(out_valid && out_ready);
    end

endmodule
